// File: rtl/trig_pkg.sv
// Shared widths, defaults, FSM encoding and event record for the trigger sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trig_pkg;

    localparam int L1A_W       = 24;
    localparam int BX_W        = 12;
    localparam logic [BX_W-1:0] BX_MAX = BX_W'(3563);
    localparam int MATCH_WIN   = 4;
    localparam int RESYNC_HOLD = 16;
    localparam int QDEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_MATCH = 2'd1,
        HOLD       = 2'd2
    } state_t;

    typedef struct packed {
        logic [L1A_W-1:0] l1a;
        logic [BX_W-1:0]  bx;
        logic             match;
    } evt_t;

endpackage

// File: rtl/trig_seq_ctrl_if.sv
// Event record valid/ready bus from the sequencer to the readout logic.
// Latency: n/a (wiring only).
// Backpressure: head is held while EVT_VALID & ~EVT_READY.
interface trig_seq_ctrl_if;
    import trig_pkg::*;

    logic             EVT_VALID;
    logic             EVT_READY;
    logic [L1A_W-1:0] EVT_L1A;
    logic [BX_W-1:0]  EVT_BX;
    logic             EVT_MATCH;

    modport master (output EVT_VALID, EVT_L1A, EVT_BX, EVT_MATCH, input EVT_READY);
    modport slave  (input EVT_VALID, EVT_L1A, EVT_BX, EVT_MATCH, output EVT_READY);

endinterface

// File: rtl/trig_evt_fifo.sv
// Event queue: DEPTH records total, including the registered head stage.
// Latency: push to head_vld is 2 edges on an empty queue (write, then head load).
// Backpressure: push on a full queue is dropped (drop pulses) unless a pop coincides.
module trig_evt_fifo
    import trig_pkg::*;
#(
    parameter int DEPTH = QDEPTH
)
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  evt_t push_dat,
    output logic drop,
    output logic head_vld,
    output evt_t head_dat,
    input  logic head_rdy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    evt_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] occ;
    logic        pop;
    logic        accept;
    logic        load;
    logic        mem_empty;

    // occ counts every record held (storage plus head), so full covers the head stage too
    assign pop       = head_vld & head_rdy;
    assign mem_empty = (wr_ptr == rd_ptr);
    assign accept    = push & ((occ != DEPTH_C) | pop);
    assign drop      = push & ~accept;
    assign load      = ~mem_empty & (~head_vld | pop);

    // storage, pointers and the registered head; flush empties without touching contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            head_vld <= 1'b0;
            head_dat <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            head_vld <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (load) begin
                head_dat <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
                head_vld <= 1'b1;
            end else if (pop) begin
                head_vld <= 1'b0;
            end
            occ <= occ + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
        end
    end

endmodule

// File: rtl/trig_seq_ctrl.sv
// Trigger sequencer: syncs raw L1A/MATCH/RESYNC/BC0, keeps BX/L1A counters, queues L1A event records.
// Latency: raw L1A+MATCH sampled at edge 0 -> pulse after edge 2 -> push at edge 3 -> EVT_VALID after edge 4.
// Backpressure: EVT_READY low holds the head; a push into a full queue is dropped and counted in OVFL_CNT.
module trig_seq_ctrl
    import trig_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             SKW_RW_L1A,
    input  logic             SKW_RW_L1A_MATCH,
    input  logic             SKW_RW_RESYNC,
    input  logic             SKW_RW_BC0,
    trig_seq_ctrl_if.master  evt,
    output logic [L1A_W-1:0] L1A_CNT,
    output logic [BX_W-1:0]  BX_CNT,
    output logic             RESYNC_BUSY,
    output logic             BC0_ERR,
    output logic [7:0]       OVFL_CNT
);

    localparam int MCW = $clog2(MATCH_WIN + 1);
    localparam int HW  = $clog2(RESYNC_HOLD + 1);
    localparam logic [MCW-1:0] MATCH_WIN_C = MCW'(MATCH_WIN);
    localparam logic [HW-1:0]  HOLD_C      = HW'(RESYNC_HOLD);

    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] sync3;
    logic [3:0] pulse;
    logic       l1a_p;
    logic       match_p;
    logic       resync_p;
    logic       bc0_p;

    state_t         state;
    state_t         state_nxt;
    evt_t           pend;
    evt_t           pend_nxt;
    evt_t           new_evt;
    evt_t           push_dat;
    logic [MCW-1:0] mcnt;
    logic [MCW-1:0] mcnt_nxt;
    logic [MCW-1:0] mcnt_inc;
    logic [HW-1:0]  hold_cnt;
    logic [HW-1:0]  hold_nxt;
    logic [HW-1:0]  hold_dec;
    logic           push;
    logic           flush;
    logic           cnt_inc;
    logic           drop;
    logic           fifo_vld;
    evt_t           fifo_dat;

    assign raw = {SKW_RW_BC0, SKW_RW_RESYNC, SKW_RW_L1A_MATCH, SKW_RW_L1A};
    assign {bc0_p, resync_p, match_p, l1a_p} = pulse;

    // two-flop synchroniser, one delay stage and a registered rising-edge pulse per input
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            pulse <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            sync3 <= sync2;
            pulse <= sync2 & ~sync3;
        end
    end

    // record for an L1A seen this cycle; match flag is set when MATCH coincides
    assign new_evt.l1a   = L1A_CNT + 1'b1;
    assign new_evt.bx    = BX_CNT;
    assign new_evt.match = match_p;
    assign mcnt_inc      = mcnt + 1'b1;
    assign hold_dec      = hold_cnt - 1'b1;

    // FSM state and pending-record registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            pend     <= '0;
            mcnt     <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pend     <= pend_nxt;
            mcnt     <= mcnt_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // next state, push decision and pending update; resync overrides everything
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        mcnt_nxt  = mcnt;
        hold_nxt  = hold_cnt;
        push      = 1'b0;
        push_dat  = pend;
        flush     = 1'b0;
        cnt_inc   = 1'b0;
        if (resync_p) begin
            flush     = 1'b1;
            state_nxt = HOLD;
            hold_nxt  = HOLD_C;
        end else begin
            case (state)
                IDLE: begin
                    if (l1a_p) begin
                        cnt_inc = 1'b1;
                        if (match_p) begin
                            push     = 1'b1;
                            push_dat = new_evt;
                        end else begin
                            pend_nxt  = new_evt;
                            mcnt_nxt  = MCW'(1);
                            state_nxt = WAIT_MATCH;
                        end
                    end
                end
                WAIT_MATCH: begin
                    if (l1a_p) begin
                        // old record goes out as-is; a coincident MATCH belongs to the new L1A
                        cnt_inc  = 1'b1;
                        push     = 1'b1;
                        push_dat = pend;
                        pend_nxt = new_evt;
                        mcnt_nxt = MCW'(1);
                    end else if (pend.match | match_p) begin
                        push           = 1'b1;
                        push_dat.match = 1'b1;
                        state_nxt      = IDLE;
                    end else if (mcnt_inc >= MATCH_WIN_C) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        mcnt_nxt = mcnt_inc;
                    end
                end
                HOLD: begin
                    if (hold_dec == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        hold_nxt = hold_dec;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // L1A counter: cleared by resync, advances even when the record is dropped
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            L1A_CNT <= '0;
        end else if (resync_p) begin
            L1A_CNT <= '0;
        end else if (cnt_inc) begin
            L1A_CNT <= L1A_CNT + 1'b1;
        end
    end

    // BX counter: free-running with wrap at BX_MAX, zeroed by resync or BC0
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BX_CNT <= '0;
        end else if (resync_p || bc0_p || (BX_CNT == BX_MAX)) begin
            BX_CNT <= '0;
        end else begin
            BX_CNT <= BX_CNT + 1'b1;
        end
    end

    // saturating drop counter, untouched by resync
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVFL_CNT <= '0;
        end else if (drop && (OVFL_CNT != 8'hFF)) begin
            OVFL_CNT <= OVFL_CNT + 1'b1;
        end
    end

    assign BC0_ERR     = bc0_p & (BX_CNT != BX_MAX);
    assign RESYNC_BUSY = (state == HOLD);

    trig_evt_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .flush    (flush),
        .push     (push),
        .push_dat (push_dat),
        .drop     (drop),
        .head_vld (fifo_vld),
        .head_dat (fifo_dat),
        .head_rdy (evt.EVT_READY)
    );

    assign evt.EVT_VALID = fifo_vld;
    assign evt.EVT_L1A   = fifo_dat.l1a;
    assign evt.EVT_BX    = fifo_dat.bx;
    assign evt.EVT_MATCH = fifo_dat.match;

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Directed bench for trig_seq_ctrl: BX/BC0, L1A/MATCH pairing, queue overflow, resync and reset.
// Latency: checks exact edge counts for the matched and unmatched paths.
// Backpressure: exercises EVT_READY low with a full queue and drains it afterwards.
module tb_trig_seq_ctrl;
    import trig_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    logic             l1a_raw;
    logic             match_raw;
    logic             resync_raw;
    logic             bc0_raw;
    logic [L1A_W-1:0] L1A_CNT;
    logic [BX_W-1:0]  BX_CNT;
    logic             RESYNC_BUSY;
    logic             BC0_ERR;
    logic [7:0]       OVFL_CNT;

    int errs   = 0;
    int checks = 0;

    trig_seq_ctrl_if evt_if ();

    trig_seq_ctrl dut (
        .CLK              (CLK),
        .RST              (RST),
        .SKW_RW_L1A       (l1a_raw),
        .SKW_RW_L1A_MATCH (match_raw),
        .SKW_RW_RESYNC    (resync_raw),
        .SKW_RW_BC0       (bc0_raw),
        .evt              (evt_if),
        .L1A_CNT          (L1A_CNT),
        .BX_CNT           (BX_CNT),
        .RESYNC_BUSY      (RESYNC_BUSY),
        .BC0_ERR          (BC0_ERR),
        .OVFL_CNT         (OVFL_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(evt_if.EVT_VALID), 0);
        chk({tag, "_l1a"},   32'(evt_if.EVT_L1A), 0);
        chk({tag, "_bx"},    32'(evt_if.EVT_BX), 0);
        chk({tag, "_match"}, 32'(evt_if.EVT_MATCH), 0);
        chk({tag, "_l1acnt"}, 32'(L1A_CNT), 0);
        chk({tag, "_bxcnt"}, 32'(BX_CNT), 0);
        chk({tag, "_busy"},  32'(RESYNC_BUSY), 0);
        chk({tag, "_bc0err"}, 32'(BC0_ERR), 0);
        chk({tag, "_ovfl"},  32'(OVFL_CNT), 0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
    endtask

    task automatic wait_bx(input int v);
        for (int i = 0; i < 4000 && BX_CNT != BX_W'(v); i++) tick();
        chk("wait_bx", 32'(BX_CNT), v);
    endtask

    task automatic wait_evt(input string tag);
        for (int i = 0; i < 40 && !evt_if.EVT_VALID; i++) tick();
        chk(tag, 32'(evt_if.EVT_VALID), 1);
    endtask

    // raw L1A for one cycle; off<0 no MATCH, off=0 MATCH together, off>0 MATCH off cycles later
    task automatic send_l1a(input int off);
        l1a_raw = 1'b1;
        if (off == 0) match_raw = 1'b1;
        tick();
        l1a_raw   = 1'b0;
        match_raw = 1'b0;
        if (off > 0) begin
            tick(off - 1);
            match_raw = 1'b1;
            tick();
            match_raw = 1'b0;
        end
    endtask

    initial begin
        int bx0;
        int n_busy;
        int guard;
        int seen;
        RST        = 1'b1;
        l1a_raw    = 1'b0;
        match_raw  = 1'b0;
        resync_raw = 1'b0;
        bc0_raw    = 1'b0;
        evt_if.EVT_READY = 1'b0;
        tick(2);
        chk_zero("reset");
        RST = 1'b0;

        // 1: aligned BC0, then a misaligned one at BX 100, then aligned again
        wait_bx(3560);
        bc0_raw = 1'b1; tick(); bc0_raw = 1'b0; tick(2);
        chk("bc0a_bx", 32'(BX_CNT), 3563);
        chk("bc0a_err", 32'(BC0_ERR), 0);
        tick();
        chk("bc0a_bx0", 32'(BX_CNT), 0);
        wait_bx(97);
        bc0_raw = 1'b1; tick(); bc0_raw = 1'b0; tick(2);
        chk("bc0x_bx", 32'(BX_CNT), 100);
        chk("bc0x_err", 32'(BC0_ERR), 1);
        tick();
        chk("bc0x_bx0", 32'(BX_CNT), 0);
        chk("bc0x_err_off", 32'(BC0_ERR), 0);
        wait_bx(3560);
        bc0_raw = 1'b1; tick(); bc0_raw = 1'b0; tick(2);
        chk("bc0b_err", 32'(BC0_ERR), 0);
        tick();
        chk("bc0b_bx0", 32'(BX_CNT), 0);

        // 2: L1A+MATCH sampled at the edge where BX becomes 500
        do_reset();
        evt_if.EVT_READY = 1'b1;
        wait_bx(499);
        send_l1a(0);
        tick(2);
        chk("m_pulse_valid", 32'(evt_if.EVT_VALID), 0);
        chk("m_pulse_cnt", 32'(L1A_CNT), 0);
        tick();
        chk("m_e3_valid", 32'(evt_if.EVT_VALID), 0);
        chk("m_e3_cnt", 32'(L1A_CNT), 1);
        tick();
        chk("m_valid", 32'(evt_if.EVT_VALID), 1);
        chk("m_l1a", 32'(evt_if.EVT_L1A), 1);
        chk("m_bx", 32'(evt_if.EVT_BX), 502);
        chk("m_match", 32'(evt_if.EVT_MATCH), 1);
        tick();
        chk("m_popped", 32'(evt_if.EVT_VALID), 0);

        // 3: unmatched L1A, match offsets inside/outside the window, retrigger, held input
        do_reset();
        evt_if.EVT_READY = 1'b1;
        bx0 = int'(BX_CNT);
        send_l1a(-1);
        tick(2);
        tick(4);
        chk("nm_early", 32'(evt_if.EVT_VALID), 0);
        tick();
        chk("nm_valid", 32'(evt_if.EVT_VALID), 1);
        chk("nm_l1a", 32'(evt_if.EVT_L1A), 1);
        chk("nm_match", 32'(evt_if.EVT_MATCH), 0);
        chk("nm_bx", 32'(evt_if.EVT_BX), bx0 + 3);
        tick();
        send_l1a(2);
        wait_evt("off2_valid");
        chk("off2_l1a", 32'(evt_if.EVT_L1A), 2);
        chk("off2_match", 32'(evt_if.EVT_MATCH), 1);
        tick();
        send_l1a(3);
        wait_evt("off3_valid");
        chk("off3_l1a", 32'(evt_if.EVT_L1A), 3);
        chk("off3_match", 32'(evt_if.EVT_MATCH), 1);
        tick();
        send_l1a(4);
        wait_evt("off4_valid");
        chk("off4_l1a", 32'(evt_if.EVT_L1A), 4);
        chk("off4_match", 32'(evt_if.EVT_MATCH), 0);
        tick(8);
        chk("off4_cnt", 32'(L1A_CNT), 4);
        l1a_raw = 1'b1; tick(); l1a_raw = 1'b0; tick();
        l1a_raw = 1'b1; match_raw = 1'b1; tick(); l1a_raw = 1'b0; match_raw = 1'b0;
        wait_evt("rt_a_valid");
        chk("rt_a_l1a", 32'(evt_if.EVT_L1A), 5);
        chk("rt_a_match", 32'(evt_if.EVT_MATCH), 0);
        tick();
        chk("rt_b_valid", 32'(evt_if.EVT_VALID), 1);
        chk("rt_b_l1a", 32'(evt_if.EVT_L1A), 6);
        chk("rt_b_match", 32'(evt_if.EVT_MATCH), 1);
        tick();
        chk("rt_empty", 32'(evt_if.EVT_VALID), 0);
        l1a_raw = 1'b1; match_raw = 1'b1; tick(10);
        l1a_raw = 1'b0; match_raw = 1'b0; tick(6);
        chk("held_cnt", 32'(L1A_CNT), 7);

        // 4: overflow with EVT_READY low, saturation, then ordered drain
        do_reset();
        evt_if.EVT_READY = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send_l1a(0);
            tick(9);
        end
        chk("ov_ovfl", 32'(OVFL_CNT), 2);
        chk("ov_cnt", 32'(L1A_CNT), 6);
        chk("ov_valid", 32'(evt_if.EVT_VALID), 1);
        chk("ov_head", 32'(evt_if.EVT_L1A), 1);
        for (int k = 0; k < 260; k++) begin
            send_l1a(0);
            tick();
        end
        tick(6);
        chk("sat_ovfl", 32'(OVFL_CNT), 255);
        chk("sat_cnt", 32'(L1A_CNT), 266);
        evt_if.EVT_READY = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_valid", 32'(evt_if.EVT_VALID), 1);
            chk("drain_l1a", 32'(evt_if.EVT_L1A), k);
            tick();
        end
        chk("drain_empty", 32'(evt_if.EVT_VALID), 0);

        // 5: resync with two records queued; L1A inside hold ignored
        evt_if.EVT_READY = 1'b0;
        send_l1a(0); tick(4);
        send_l1a(0); tick(6);
        chk("rs_pre_valid", 32'(evt_if.EVT_VALID), 1);
        chk("rs_pre_head", 32'(evt_if.EVT_L1A), 267);
        resync_raw = 1'b1; tick(); resync_raw = 1'b0; tick(2);
        chk("rs_pulse_busy", 32'(RESYNC_BUSY), 0);
        tick();
        chk("rs_busy", 32'(RESYNC_BUSY), 1);
        chk("rs_cnt", 32'(L1A_CNT), 0);
        chk("rs_bx", 32'(BX_CNT), 0);
        chk("rs_valid", 32'(evt_if.EVT_VALID), 0);
        chk("rs_ovfl", 32'(OVFL_CNT), 255);
        n_busy = 1;
        l1a_raw = 1'b1; match_raw = 1'b1;
        tick();
        if (RESYNC_BUSY) n_busy++;
        l1a_raw = 1'b0; match_raw = 1'b0;
        guard = 0;
        while (RESYNC_BUSY && guard < 40) begin
            tick();
            if (RESYNC_BUSY) n_busy++;
            guard++;
        end
        chk("rs_busy_len", 32'(n_busy), 16);
        chk("rs_hold_cnt", 32'(L1A_CNT), 0);
        chk("rs_hold_valid", 32'(evt_if.EVT_VALID), 0);
        send_l1a(0);
        wait_evt("rs_first_valid");
        chk("rs_first_l1a", 32'(evt_if.EVT_L1A), 1);
        chk("rs_first_match", 32'(evt_if.EVT_MATCH), 1);

        // 6: reset during WAIT_MATCH with a record queued
        send_l1a(-1);
        tick(3);
        RST = 1'b1;
        #1;
        chk_zero("midrst");
        tick(2);
        RST = 1'b0;
        evt_if.EVT_READY = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (evt_if.EVT_VALID) seen = 1;
        end
        chk("midrst_no_evt", 32'(seen), 0);
        chk("midrst_cnt", 32'(L1A_CNT), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/trig_seq_ctrl.md
Name: trig_seq_ctrl

Overview:
- Trigger sequencer for the DCFEB skew-clear trigger inputs: L1A, L1A_MATCH, RESYNC and BC0.
- Takes the raw single-ended outputs of the differential input buffers and synchronises and edge-detects them.
- Maintains the bunch-crossing (BX) and L1A counters and applies resync hold-off.
- Pairs each L1A with its match flag and queues event records for the readout logic through a valid/ready interface.

Parameters:
- L1A_W, 24, L1A counter width
- BX_W, 12, BX counter width
- BX_MAX, 3563, last BX value before wrap
- MATCH_WIN, 4, cycles (including the L1A cycle) in which L1A_MATCH is accepted
- RESYNC_HOLD, 16, cycles L1A is ignored after a resync
- QDEPTH, 4, event queue depth (power of 2)

Ports:
- CLK  in  1  40 MHz LHC clock
- RST  in  1  asynchronous, active-high reset
- SKW_RW_L1A  in  1  raw L1A from input buffer, asynchronous
- SKW_RW_L1A_MATCH  in  1  raw L1A match, asynchronous
- SKW_RW_RESYNC  in  1  raw resync, asynchronous
- SKW_RW_BC0  in  1  raw BC0, asynchronous
- EVT_VALID  out  1  queue head valid
- EVT_READY  in  1  consumer accepts head
- EVT_L1A  out  L1A_W  head L1A number
- EVT_BX  out  BX_W  head BX at L1A
- EVT_MATCH  out  1  head match flag
- L1A_CNT  out  L1A_W  live L1A count
- BX_CNT  out  BX_W  live BX count
- RESYNC_BUSY  out  1  high during resync hold-off
- BC0_ERR  out  1  one-cycle pulse when BC0 arrives while BX_CNT != BX_MAX
- OVFL_CNT  out  8  saturating count of dropped events

Behaviour:
- Reset: all outputs 0; all sync flops, counters and queue cleared; FSM in IDLE.
- Input conditioning:
  - Each raw input passes through a 2-FF synchroniser, then rising-edge detection (sync2 & ~sync3).
  - Each detected edge gives a one-cycle internal pulse: l1a_p, match_p, resync_p, bc0_p.
  - An input held high produces exactly one pulse.
- BX counter:
  - Increments every cycle and wraps BX_MAX -> 0.
  - bc0_p: BX_CNT = 0 next cycle. BC0_ERR pulses in the same cycle as bc0_p if BX_CNT != BX_MAX.
  - resync_p: BX_CNT = 0 next cycle. resync_p has priority over bc0_p.
- FSM states: IDLE, WAIT_MATCH, HOLD.
  - IDLE:
    - l1a_p -> increment L1A_CNT.
    - Latch pending {L1A_CNT+1, BX_CNT}; match counter = 1.
    - If match_p is in the same cycle, push with match=1 and stay in IDLE; otherwise go to WAIT_MATCH.
  - WAIT_MATCH:
    - match_p -> push pending with match=1 -> IDLE.
    - Match counter reaches MATCH_WIN without match -> push with match=0 -> IDLE.
    - New l1a_p -> push old pending with match=0, latch new pending and restart the window. A coincident match_p belongs to the new L1A.
  - Any state, resync_p:
    - Discard pending, flush queue, L1A_CNT = 0, OVFL_CNT unchanged.
    - HOLD, load hold counter with RESYNC_HOLD.
  - HOLD:
    - RESYNC_BUSY = 1; l1a_p and match_p ignored (not counted).
    - resync_p reloads the hold counter; at 0 -> IDLE.
- Queue and counters:
  - At most one push per cycle.
  - Push when full: record dropped, OVFL_CNT += 1, saturating at 255. L1A_CNT still advances.
  - Pop when EVT_VALID & EVT_READY. Push and pop in the same cycle on a full queue is allowed (no drop).
  - EVT_* outputs are registered; head is stable while EVT_VALID & ~EVT_READY.
  - L1A_CNT wraps at 2^L1A_W-1 -> 0.
- Latency:
  - Raw L1A and MATCH both sampled high at edge 0 -> l1a_p in cycle after edge 2 -> push at edge 3 -> EVT_VALID = 1 after edge 4, when the queue was empty.
  - No-match case: EVT_VALID follows MATCH_WIN-1 cycles later.
- Reset mid-operation: asynchronous clear of everything, including the queue contents.

Decomposition:
- Package trig_pkg:
  - Widths and defaults: L1A_W, BX_W, BX_MAX.
  - FSM state encoding.
  - Event record struct {l1a, bx, match}.
- One sub-module: trig_evt_fifo, a synchronous QDEPTH-deep FIFO with full/empty, registered head and flush input.
- Synchronisers and edge detectors stay inline.

Test Plan:
1. Reset release, BC0 raw pulse every 3564 cycles -> BX_CNT reads 0 two cycles after each bc0_p edge sequence; BC0_ERR never pulses. An extra BC0 at BX 100 -> BC0_ERR one cycle, BX_CNT 0 next cycle.
2. L1A and MATCH raw high together for 1 cycle at BX 500, EVT_READY=1 -> one event {L1A=1, BX=502, MATCH=1}; EVT_VALID high 4 edges after sampling.
3. L1A alone, no match -> event {L1A=1, MATCH=0} appears after the MATCH_WIN=4 window. L1A at cycle 0 and match at cycle 2 -> MATCH=1.
4. EVT_READY=0, 6 matched L1As 10 cycles apart -> 4 queued (L1A 1..4), OVFL_CNT=2, L1A_CNT=6. Then EVT_READY=1 -> pops 1,2,3,4 in order.
5. Resync with 2 events queued -> queue empty, L1A_CNT=0, BX_CNT=0, RESYNC_BUSY high 16 cycles. An L1A inside hold is ignored; the first L1A after hold is numbered 1.
6. Assert RST during WAIT_MATCH with a non-empty queue -> all outputs 0 immediately; no event emitted after release.
